// File: rtl/pc_pkg.sv
// Shared pc_gen definitions: next-PC source encodings and default vectors.
package pc_pkg;

   localparam logic [2:0] PC_SEL_SEQ     = 3'd0;
   localparam logic [2:0] PC_SEL_NPC     = 3'd1;
   localparam logic [2:0] PC_SEL_NPC_REG = 3'd2;
   localparam logic [2:0] PC_SEL_EPC     = 3'd3;

   localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_3000;
   localparam logic [31:0] PC_EXC_VEC_DEF   = 32'h0000_4180;

   typedef enum logic {
      BUF_IDLE = 1'b0,
      BUF_HELD = 1'b1
   } buf_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry redirect buffer: keeps the newest redirect seen while fetch is stalled.
// Updates at each posedge; drained (cleared) on the first unstalled cycle or an exception.
module pc_redirect_buf
   import pc_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              exc_i,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic              pend_valid_o,
   output logic [ADDR_W-1:0] pend_addr_o
);

   buf_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q <= BUF_IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // An unstalled cycle always consumes the entry: either the buffered target
   // is loaded into pc, or a live redirect supersedes it.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      if (exc_i) begin
         state_d = BUF_IDLE;
      end else if (stall_i) begin
         if (redirect_i) begin
            state_d = BUF_HELD;
            addr_d  = target_i;
         end
      end else begin
         state_d = BUF_IDLE;
      end
   end

   assign pend_valid_o = (state_q == BUF_HELD);
   assign pend_addr_o  = addr_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: priority mux over reset/exception/redirect/buffer/sequential, pc registered (1 cycle).
// Stall freezes pc except for exceptions; `PC_ALIGN_CHECK_EN adds a registered misaligned-fetch flag.
module pc_gen
   import pc_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC_DEF),
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(PC_EXC_VEC_DEF),
   parameter int                STEP      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic [2:0]        pc_sel,
   input  logic [ADDR_W-1:0] npc,
   input  logic [ADDR_W-1:0] npc_reg,
   input  logic [ADDR_W-1:0] epc,
   input  logic              exc_req,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc8,
   output logic              pend_valid,
   output logic              addr_err
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] pend_addr;
   logic              redirect;

   always_comb begin
      redirect = 1'b1;
      target   = npc;
      case (pc_sel)
         PC_SEL_NPC:     target = npc;
         PC_SEL_NPC_REG: target = npc_reg;
         PC_SEL_EPC:     target = epc;
         default:        redirect = 1'b0;
      endcase
   end

   pc_redirect_buf #(
      .ADDR_W(ADDR_W)
   ) u_redirect_buf (
      .clk         (clk),
      .reset_i     (reset),
      .exc_i       (exc_req),
      .stall_i     (stall),
      .redirect_i  (redirect),
      .target_i    (target),
      .pend_valid_o(pend_valid),
      .pend_addr_o (pend_addr)
   );

   // A live redirect outranks the buffered one when both are present.
   always_comb begin
      pc_d = pc_q;
      if (exc_req) begin
         pc_d = EXC_VEC;
      end else if (!stall) begin
         if (redirect)
            pc_d = target;
         else if (pend_valid)
            pc_d = pend_addr;
         else
            pc_d = pc_q + ADDR_W'(STEP);
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         pc_q <= RESET_VEC;
      else
         pc_q <= pc_d;
   end

   assign pc  = pc_q;
   assign pc8 = pc_q + ADDR_W'(2 * STEP);

`ifdef PC_ALIGN_CHECK_EN
   logic addr_err_q;

   always_ff @(posedge clk) begin
      if (reset)
         addr_err_q <= 1'b0;
      else if (exc_req || !stall)
         addr_err_q <= |pc_d[1:0];
   end

   assign addr_err = addr_err_q;
`else
   assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (32-bit default instance plus an 8-bit wrap instance).
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic [2:0]  pc_sel = 3'd0;
   logic        exc_req = 1'b0;
   logic [31:0] npc = '0, npc_reg = '0, epc = '0;
   logic [31:0] pc, pc8;
   logic        pend_valid, addr_err;

   logic [7:0]  npc_b = '0, npc_reg_b = '0, epc_b = '0;
   logic [7:0]  pc_b, pc8_b;
   logic        pend_valid_b, addr_err_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_gen dut (
      .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel),
      .npc(npc), .npc_reg(npc_reg), .epc(epc), .exc_req(exc_req),
      .pc(pc), .pc8(pc8), .pend_valid(pend_valid), .addr_err(addr_err)
   );

   pc_gen #(
      .ADDR_W(8), .RESET_VEC(8'h30), .EXC_VEC(8'h80), .STEP(4)
   ) dut8 (
      .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel),
      .npc(npc_b), .npc_reg(npc_reg_b), .epc(epc_b), .exc_req(exc_req),
      .pc(pc_b), .pc8(pc8_b), .pend_valid(pend_valid_b), .addr_err(addr_err_b)
   );

   task automatic cyc(input logic st, input logic [2:0] sel, input logic ex);
      stall   = st;
      pc_sel  = sel;
      exc_req = ex;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
      checks++; if (pc8 !== 32'h3008) begin errors++; $display("FAIL reset_pc8 got=%h exp=%h", pc8, 32'h3008); end
      checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL reset_pend got=%b exp=0", pend_valid); end
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
   endtask

   task automatic test_seq();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'h3004; exp_pc[1] = 32'h3008; exp_pc[2] = 32'h300C;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0);
         checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, exp_pc[i]); end
         checks++; if (pc8 !== exp_pc[i] + 32'd8) begin errors++; $display("FAIL seq_pc8_%0d got=%h exp=%h", i, pc8, exp_pc[i] + 32'd8); end
      end
   endtask

   task automatic test_stall_redirect();
      npc = 32'h3100;
      cyc(1, 1, 0);
      checks++; if (pc !== 32'h300C || pend_valid !== 1'b1) begin errors++; $display("FAIL stall_load pc=%h pend=%b exp=300c/1", pc, pend_valid); end
      for (int i = 0; i < 2; i++) begin
         cyc(1, 0, 0);
         checks++; if (pc !== 32'h300C || pend_valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d pc=%h pend=%b exp=300c/1", i, pc, pend_valid); end
      end
      cyc(0, 0, 0);
      checks++; if (pc !== 32'h3100 || pend_valid !== 1'b0) begin errors++; $display("FAIL stall_release pc=%h pend=%b exp=3100/0", pc, pend_valid); end
   endtask

   task automatic test_overwrite();
      npc = 32'h3100; npc_reg = 32'h3200;
      cyc(1, 1, 0);
      cyc(1, 2, 0);
      checks++; if (pc !== 32'h3100 || pend_valid !== 1'b1) begin errors++; $display("FAIL ovr_held pc=%h pend=%b exp=3100/1", pc, pend_valid); end
      cyc(0, 0, 0);
      checks++; if (pc !== 32'h3200 || pend_valid !== 1'b0) begin errors++; $display("FAIL ovr_newest pc=%h pend=%b exp=3200/0", pc, pend_valid); end
      npc = 32'h3300; epc = 32'h3400;
      cyc(1, 1, 0);
      cyc(0, 3, 0);
      checks++; if (pc !== 32'h3400 || pend_valid !== 1'b0) begin errors++; $display("FAIL ovr_live_wins pc=%h pend=%b exp=3400/0", pc, pend_valid); end
      cyc(0, 0, 0);
      checks++; if (pc !== 32'h3404) begin errors++; $display("FAIL ovr_no_replay pc=%h exp=3404", pc); end
   endtask

   task automatic test_exception();
      npc = 32'h3500;
      cyc(1, 1, 0);
      cyc(1, 0, 1);
      checks++; if (pc !== 32'h4180 || pend_valid !== 1'b0) begin errors++; $display("FAIL exc_stall pc=%h pend=%b exp=4180/0", pc, pend_valid); end
      epc = 32'h3010;
      cyc(0, 3, 0);
      checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL exc_eret pc=%h exp=3010", pc); end
      cyc(0, 7, 0);
      checks++; if (pc !== 32'h3014) begin errors++; $display("FAIL sel7_seq pc=%h exp=3014", pc); end
      reset = 1'b1;
      cyc(0, 1, 1);
      reset = 1'b0;
      checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_beats_exc pc=%h exp=3000", pc); end
   endtask

   task automatic test_wrap_and_reset_held();
      npc_b = 8'hFC;
      cyc(0, 1, 0);
      checks++; if (pc_b !== 8'hFC || pc8_b !== 8'h04) begin errors++; $display("FAIL w8_load pc=%h pc8=%h exp=fc/04", pc_b, pc8_b); end
      cyc(0, 0, 0);
      checks++; if (pc_b !== 8'h00 || pc8_b !== 8'h08) begin errors++; $display("FAIL w8_wrap pc=%h pc8=%h exp=00/08", pc_b, pc8_b); end
      npc_b = 8'h40; npc = 32'h3600;
      cyc(1, 1, 0);
      checks++; if (pend_valid_b !== 1'b1 || pend_valid !== 1'b1) begin errors++; $display("FAIL held_pre_reset pend8=%b pend=%b exp=1/1", pend_valid_b, pend_valid); end
      reset = 1'b1;
      cyc(1, 0, 0);
      reset = 1'b0;
      checks++; if (pc_b !== 8'h30 || pend_valid_b !== 1'b0) begin errors++; $display("FAIL w8_reset_held pc=%h pend=%b exp=30/0", pc_b, pend_valid_b); end
      checks++; if (pc !== 32'h3000 || pend_valid !== 1'b0) begin errors++; $display("FAIL reset_held pc=%h pend=%b exp=3000/0", pc, pend_valid); end
      cyc(0, 0, 0);
      checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL reset_discard pc=%h exp=3004", pc); end
   endtask

   task automatic test_align();
      logic exp_set;
`ifdef PC_ALIGN_CHECK_EN
      exp_set = 1'b1;
`else
      exp_set = 1'b0;
`endif
      npc = 32'h3102;
      cyc(0, 1, 0);
      checks++; if (pc !== 32'h3102 || addr_err !== exp_set) begin errors++; $display("FAIL align_set pc=%h err=%b exp=3102/%b", pc, addr_err, exp_set); end
      cyc(1, 0, 0);
      checks++; if (addr_err !== exp_set) begin errors++; $display("FAIL align_hold err=%b exp=%b", addr_err, exp_set); end
      cyc(0, 0, 0);
      checks++; if (pc !== 32'h3106 || addr_err !== exp_set) begin errors++; $display("FAIL align_seq pc=%h err=%b exp=3106/%b", pc, addr_err, exp_set); end
      cyc(0, 0, 1);
      checks++; if (pc !== 32'h4180 || addr_err !== 1'b0) begin errors++; $display("FAIL align_exc pc=%h err=%b exp=4180/0", pc, addr_err); end
   endtask

   initial begin
      test_reset();
      test_seq();
      test_stall_redirect();
      test_overwrite();
      test_exception();
      test_wrap_and_reset_held();
      test_align();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
